// File: rtl/matrix_ls_sequencer.sv
// Matrix load/store sequencer: splits one matrix memory op into ROWS row transactions.
// Optional MATRIX_LS_ALIGN_CHECK_EN rejects misaligned base/stride at accept with err.
module matrix_ls_sequencer #(
  parameter  int ROWS   = 4,
  parameter  int ROW_W  = 64,
  parameter  int ADDR_W = 32,
  parameter  int MREGS  = 16,
  localparam int ROW_IW = $clog2(ROWS),
  localparam int SEL_W  = $clog2(MREGS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [SEL_W-1:0]  req_mreg,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_stride,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ROW_W-1:0]  mem_wdata,
  input  logic              mem_ack,
  input  logic [ROW_W-1:0]  mem_rdata,
  output logic [SEL_W-1:0]  mrf_rd_sel,
  output logic [ROW_IW-1:0] mrf_rd_row,
  input  logic [ROW_W-1:0]  mrf_rd_data,
  output logic              mrf_wr_en,
  output logic [SEL_W-1:0]  mrf_wr_sel,
  output logic [ROW_IW-1:0] mrf_wr_row,
  output logic [ROW_W-1:0]  mrf_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_REQ  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [ROW_IW-1:0] LAST_ROW = ROW_IW'(ROWS - 1);

  state_t              state_r;
  state_t              state_n;
  logic                is_store_r;
  logic [SEL_W-1:0]    mreg_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   stride_r;
  logic [ROW_IW-1:0]   row_r;
  logic [ROW_W-1:0]    wdata_r;
  logic                accept_s;
  logic                align_fail_s;
  logic                row_ack_s;

  assign accept_s  = req_valid && (state_r == ST_IDLE);
  assign row_ack_s = (state_r == ST_REQ) && mem_ack;

`ifdef MATRIX_LS_ALIGN_CHECK_EN
  localparam int OFF_W = $clog2(ROW_W / 8);
  logic err_r;

  assign align_fail_s = (|req_base[OFF_W-1:0]) | (|req_stride[OFF_W-1:0]);
  assign err          = (state_r == ST_DONE) && err_r;

  // Alignment verdict captured at accept, reported alongside done.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= align_fail_s;
    end
  end
`else
  assign align_fail_s = 1'b0;
  assign err          = 1'b0;
`endif

  // State register plus latched request fields and the row/address walker.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      is_store_r <= 1'b0;
      mreg_r     <= '0;
      addr_r     <= '0;
      stride_r   <= '0;
      row_r      <= '0;
      wdata_r    <= '0;
    end else begin
      state_r <= state_n;
      if (accept_s) begin
        is_store_r <= req_is_store;
        mreg_r     <= req_mreg;
        addr_r     <= req_base;
        stride_r   <= req_stride;
        row_r      <= '0;
      end else if (row_ack_s) begin
        addr_r <= addr_r + stride_r;
        row_r  <= row_r + ROW_IW'(1);
      end
      if (state_r == ST_RD) begin
        wdata_r <= mrf_rd_data;
      end
    end
  end

  // Next-state logic: one row retires per mem_ack while in REQ.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          if (align_fail_s) begin
            state_n = ST_DONE;
          end else if (req_is_store) begin
            state_n = ST_RD;
          end else begin
            state_n = ST_REQ;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RD: state_n = ST_REQ;
      ST_REQ: begin
        if (mem_ack) begin
          if (row_r == LAST_ROW) begin
            state_n = ST_DONE;
          end else if (is_store_r) begin
            state_n = ST_RD;
          end else begin
            state_n = ST_REQ;
          end
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Status and handshake decodes of the registered state.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    mem_req   = 1'b0;
    mem_wen   = 1'b0;
    done      = 1'b0;
    case (state_r)
      ST_IDLE: req_ready = 1'b1;
      ST_RD:   busy      = 1'b1;
      ST_REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_wen = is_store_r;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

  assign mem_addr    = addr_r;
  assign mem_wdata   = wdata_r;
  assign mrf_rd_sel  = mreg_r;
  assign mrf_rd_row  = row_r;
  // Load write-back is same-cycle with the ack; a reset in that cycle suppresses it.
  assign mrf_wr_en   = row_ack_s && !is_store_r && !RST;
  assign mrf_wr_sel  = mreg_r;
  assign mrf_wr_row  = row_r;
  assign mrf_wr_data = mem_rdata;

endmodule

// File: tb/tb_matrix_ls_sequencer.sv
// Scoreboard bench for matrix_ls_sequencer: memory/MRF models plus expected-transaction queues.
// Alignment expectations follow MATRIX_LS_ALIGN_CHECK_EN.
module tb_matrix_ls_sequencer;
  localparam int ROWS = 4;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic [1:0]  row;
    logic [63:0] data;
  } wr_exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [3:0]  req_mreg = 4'd0;
  logic [31:0] req_base = 32'd0;
  logic [31:0] req_stride = 32'd0;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = 64'd0;
  logic [3:0]  mrf_rd_sel;
  logic [1:0]  mrf_rd_row;
  logic [63:0] mrf_rd_data;
  logic        mrf_wr_en;
  logic [3:0]  mrf_wr_sel;
  logic [1:0]  mrf_wr_row;
  logic [63:0] mrf_wr_data;
  logic        busy;
  logic        done;
  logic        err;

  logic [63:0] mrf [16][4];
  mem_exp_t    exp_mem[$];
  wr_exp_t     exp_wr[$];
  logic [63:0] rdq[$];

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          mem_dly = 0;
  int          wait_cnt = 0;
  logic        stray_en = 1'b0;
  logic        mem_hold = 1'b0;

  matrix_ls_sequencer dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_mreg(req_mreg), .req_base(req_base), .req_stride(req_stride),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mrf_rd_sel(mrf_rd_sel), .mrf_rd_row(mrf_rd_row), .mrf_rd_data(mrf_rd_data),
    .mrf_wr_en(mrf_wr_en), .mrf_wr_sel(mrf_wr_sel), .mrf_wr_row(mrf_wr_row),
    .mrf_wr_data(mrf_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  assign mrf_rd_data = mrf[mrf_rd_sel][mrf_rd_row];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Memory responder (ack after mem_dly waiting cycles) and output scoreboard.
  always @(negedge CLK) begin
    if (mem_hold) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (wait_cnt >= mem_dly) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (!mem_wen && rdq.size() > 0) mem_rdata = rdq.pop_front();
        else mem_rdata = {$urandom, $urandom};
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else if (stray_en) begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom};
    end else begin
      mem_ack = 1'b0;
    end
    #1;
    if (mem_req) begin
      if (exp_mem.size() == 0) begin
        chk("mem_req_unexpected", 64'd1, 64'd0);
      end else begin
        chk("mem_wen", 64'(mem_wen), 64'(exp_mem[0].wen));
        chk("mem_addr", 64'(mem_addr), 64'(exp_mem[0].addr));
        if (exp_mem[0].wen) chk("mem_wdata", mem_wdata, exp_mem[0].wdata);
        if (mem_ack) void'(exp_mem.pop_front());
      end
    end
    if (mrf_wr_en) begin
      wr_exp_t e;
      wr_cnt++;
      if (exp_wr.size() == 0) begin
        chk("mrf_wr_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_wr.pop_front();
        chk("mrf_wr_sel", 64'(mrf_wr_sel), 64'(e.sel));
        chk("mrf_wr_row", 64'(mrf_wr_row), 64'(e.row));
        chk("mrf_wr_data", mrf_wr_data, e.data);
      end
    end
  end

  task automatic push_exp(input logic st, input logic [3:0] mreg,
                          input logic [31:0] base, input logic [31:0] stride);
    for (int r = 0; r < ROWS; r++) begin
      mem_exp_t m;
      wr_exp_t  w;
      m.wen   = st;
      m.addr  = base + stride * 32'(r);
      m.wdata = st ? mrf[mreg][r] : 64'd0;
      exp_mem.push_back(m);
      if (!st) begin
        w.sel  = mreg;
        w.row  = 2'(r);
        w.data = {$urandom, $urandom};
        exp_wr.push_back(w);
        rdq.push_back(w.data);
      end
    end
  endtask

  task automatic scramble();
    req_is_store = 1'($urandom);
    req_mreg     = 4'($urandom);
    req_base     = $urandom;
    req_stride   = $urandom;
  endtask

  task automatic wait_accept(output int a);
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge CLK);
    chk("accept_ready", 64'(req_ready), 64'd1);
    a = cyc;
  endtask

  task automatic wait_done(input int a, input int lat, input logic eerr);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      #2;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("done_latency", 64'(cyc - a + 1), 64'(lat));
      chk("err", 64'(err), 64'(eerr));
    end
    @(negedge CLK);
    #2;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("ready_after_done", 64'(req_ready), 64'd1);
  endtask

  task automatic do_op(input logic st, input logic [3:0] mreg, input logic [31:0] base,
                       input logic [31:0] stride, input int dly, input logic exp_err);
    int a;
    int lat;
    mem_dly = dly;
    if (!exp_err) push_exp(st, mreg, base, stride);
    lat = st ? (2 + ROWS * (2 + dly)) : (2 + ROWS * (1 + dly));
    if (exp_err) lat = 2;
    @(negedge CLK);
    req_valid = 1'b1; req_is_store = st; req_mreg = mreg; req_base = base; req_stride = stride;
    wait_accept(a);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    scramble();
    wait_done(a, lat, exp_err);
  endtask

  initial begin
    int a;
    int b;
    int w0;
    logic align_err;
    for (int s = 0; s < 16; s++)
      for (int r = 0; r < 4; r++) mrf[s][r] = {$urandom, $urandom};

    repeat (3) @(negedge CLK);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_mrf_wr_en", 64'(mrf_wr_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    RST = 1'b0;

    do_op(1'b0, 4'd3, 32'h0000_1000, 32'h0000_0040, 0, 1'b0);

    stray_en = 1'b1;
    do_op(1'b1, 4'd5, 32'h0000_2000, 32'h0000_0040, 2, 1'b0);
    repeat (6) @(negedge CLK);
    stray_en = 1'b0;

    do_op(1'b0, 4'd1, 32'hFFFF_FFF0, 32'h0000_0010, 1, 1'b0);
    do_op(1'b1, 4'd9, 32'h0000_2000, 32'h0000_0000, 0, 1'b0);

    // Back-to-back with req_valid held: second op must wait for IDLE.
    mem_dly = 0;
    push_exp(1'b0, 4'd2, 32'h0000_3000, 32'h0000_0008);
    push_exp(1'b1, 4'd4, 32'h0000_4000, 32'h0000_0100);
    @(negedge CLK);
    req_valid = 1'b1; req_is_store = 1'b0; req_mreg = 4'd2;
    req_base = 32'h0000_3000; req_stride = 32'h0000_0008;
    wait_accept(a);
    @(posedge CLK);
    #1;
    req_is_store = 1'b1; req_mreg = 4'd4; req_base = 32'h0000_4000; req_stride = 32'h0000_0100;
    wait_done(a, 6, 1'b0);
    b = cyc;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    scramble();
    wait_done(b, 10, 1'b0);

    // Reset after the second row of a load has been acknowledged.
    mem_dly = 0;
    w0 = wr_cnt;
    push_exp(1'b0, 4'd7, 32'h0000_5000, 32'h0000_0020);
    @(negedge CLK);
    req_valid = 1'b1; req_is_store = 1'b0; req_mreg = 4'd7;
    req_base = 32'h0000_5000; req_stride = 32'h0000_0020;
    wait_accept(a);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    mem_hold = 1'b1;
    @(posedge CLK);
    #1;
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    RST = 1'b0;
    exp_mem.delete();
    exp_wr.delete();
    rdq.delete();
    wait_cnt = 0;
    mem_hold = 1'b0;
    repeat (5) @(negedge CLK);
    chk("midrst_rows_written", 64'(wr_cnt - w0), 64'd2);

`ifdef MATRIX_LS_ALIGN_CHECK_EN
    align_err = 1'b1;
`else
    align_err = 1'b0;
`endif
    do_op(1'b0, 4'd6, 32'h0000_1004, 32'h0000_0040, 0, align_err);

    do_op(1'b0, 4'd10, 32'h0000_8000, 32'h0000_0040, 0, 1'b0);

    stray_en = 1'b1;
    repeat (6) @(negedge CLK);
    stray_en = 1'b0;
    repeat (2) @(negedge CLK);
    chk("exp_mem_drained", 64'(exp_mem.size()), 64'd0);
    chk("exp_wr_drained", 64'(exp_wr.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
